// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and helpers for the dual-port RAM arbiter.
package ram_arb_pkg;
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;
    localparam int MAX_REQ = 8;
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ram_dp_arbiter_rr_pick2.sv
// rr_pick2: picks the first two set bits of mask, scanning upward from ptr with wrap-around.
module rr_pick2 #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  g0_oh,
    output logic [N-1:0]  g1_oh,
    output logic [IW-1:0] g0_idx,
    output logic [IW-1:0] g1_idx,
    output logic          g0_vld,
    output logic          g1_vld
);
    logic [IW-1:0] j;
    always_comb begin
        g0_vld = 1'b0;
        g1_vld = 1'b0;
        g0_idx = '0;
        g1_idx = '0;
        g0_oh  = '0;
        g1_oh  = '0;
        j      = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (mask[j]) begin
                if (!g0_vld) begin
                    g0_vld   = 1'b1;
                    g0_idx   = j;
                    g0_oh[j] = 1'b1;
                end else if (!g1_vld) begin
                    g1_vld   = 1'b1;
                    g1_idx   = j;
                    g1_oh[j] = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/ram_dp_arbiter.sv
// ram_dp_arbiter: grants up to two requesters per cycle onto a dual-port RAM and routes read data back.
// Define RAM_DP_ARBITER_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module ram_dp_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int BWEN_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_wen,
    input  logic [NUM_REQ*BWEN_WIDTH-1:0] req_bwen,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
    output logic                          ram_cen,
    output logic                          ram_wen_a,
    output logic                          ram_wen_b,
    output logic [BWEN_WIDTH-1:0]         ram_bwen_a,
    output logic [BWEN_WIDTH-1:0]         ram_bwen_b,
    output logic [ADDR_WIDTH-1:0]         ram_addr_a,
    output logic [ADDR_WIDTH-1:0]         ram_addr_b,
    output logic [DATA_WIDTH-1:0]         ram_din_a,
    output logic [DATA_WIDTH-1:0]         ram_din_b,
    input  logic [DATA_WIDTH-1:0]         ram_dout_a,
    input  logic [DATA_WIDTH-1:0]         ram_dout_b
);
    localparam int IW = id_width(NUM_REQ);

    logic [IW-1:0]         ptr, g0_idx, g1_idx, rd_id_a, rd_id_b;
    logic [NUM_REQ-1:0]    g0_oh, g1_oh;
    logic                  g0_vld, g1_vld, conflict, gnt_a, gnt_b, rd_vld_a, rd_vld_b;
    logic [ADDR_WIDTH-1:0] addr_g0, addr_g1;

    rr_pick2 #(.N(NUM_REQ), .IW(IW)) u_pick (
        .mask   (req_valid),
        .ptr    (ptr),
        .g0_oh  (g0_oh),
        .g1_oh  (g1_oh),
        .g0_idx (g0_idx),
        .g1_idx (g1_idx),
        .g0_vld (g0_vld),
        .g1_vld (g1_vld)
    );

    assign addr_g0 = req_addr[g0_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign addr_g1 = req_addr[g1_idx*ADDR_WIDTH +: ADDR_WIDTH];
    // Same-address pairs involving a write are serialised so a following read sees the new data.
    assign conflict = g0_vld & g1_vld & (addr_g0 == addr_g1) & (req_wen[g0_idx] | req_wen[g1_idx]);
    assign gnt_a = reset_n & g0_vld;
    assign gnt_b = reset_n & g1_vld & ~conflict;

    assign req_ready  = (gnt_a ? g0_oh : '0) | (gnt_b ? g1_oh : '0);
    assign ram_cen    = gnt_a | gnt_b;
    assign ram_wen_a  = gnt_a & req_wen[g0_idx];
    assign ram_wen_b  = gnt_b & req_wen[g1_idx];
    assign ram_bwen_a = gnt_a ? req_bwen[g0_idx*BWEN_WIDTH +: BWEN_WIDTH] : '0;
    assign ram_bwen_b = gnt_b ? req_bwen[g1_idx*BWEN_WIDTH +: BWEN_WIDTH] : '0;
    assign ram_addr_a = gnt_a ? addr_g0 : '0;
    assign ram_addr_b = gnt_b ? addr_g1 : '0;
    assign ram_din_a  = gnt_a ? req_din[g0_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign ram_din_b  = gnt_b ? req_din[g1_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

`ifdef RAM_DP_ARBITER_FIXED_PRIO_EN
    assign ptr = '0;
`else
    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ptr <= '0;
        else if (gnt_b) ptr <= nxt(g1_idx);
        else if (gnt_a) ptr <= nxt(g0_idx);
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_a <= 1'b0;
            rd_vld_b <= 1'b0;
            rd_id_a  <= '0;
            rd_id_b  <= '0;
        end else begin
            rd_vld_a <= gnt_a & ~req_wen[g0_idx];
            rd_vld_b <= gnt_b & ~req_wen[g1_idx];
            rd_id_a  <= g0_idx;
            rd_id_b  <= g1_idx;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
        logic hit_a, hit_b;
        assign hit_a = rd_vld_a && (rd_id_a == IW'(i));
        assign hit_b = rd_vld_b && (rd_id_b == IW'(i));
        assign rsp_valid[i] = hit_a | hit_b;
        assign rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = hit_a ? ram_dout_a : hit_b ? ram_dout_b : '0;
    end
endmodule

// File: tb/tb_ram_dp_arbiter.sv
// tb_ram_dp_arbiter: directed and random checks of ram_dp_arbiter against a scan-order reference model.
module tb_ram_dp_arbiter;
    localparam int N = 4, DW = 32, AW = 4, BW = 4;

    logic clock = 1'b0, reset_n = 1'b0;
    logic [N-1:0] req_valid = '0, req_wen = '0, req_ready, rsp_valid;
    logic [N*BW-1:0] req_bwen;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_din, rsp_data;
    logic ram_cen, ram_wen_a, ram_wen_b;
    logic [BW-1:0] ram_bwen_a, ram_bwen_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
    logic [AW-1:0] a[N];
    logic [BW-1:0] be[N];
    logic [DW-1:0] d[N];
    logic [DW-1:0] mem[16];
    logic [DW-1:0] ref_mem[16];
    logic [N-1:0] exp_rv, exp_ready;
    logic [N*DW-1:0] exp_rd;
    int mptr, passed = 0, total = 0;
    int cnt[N];

    assign req_addr = {a[3], a[2], a[1], a[0]};
    assign req_bwen = {be[3], be[2], be[1], be[0]};
    assign req_din  = {d[3], d[2], d[1], d[0]};

    always #5 clock = ~clock;

    ram_dp_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_bwen(req_bwen), .req_addr(req_addr), .req_din(req_din),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ram_cen(ram_cen), .ram_wen_a(ram_wen_a), .ram_wen_b(ram_wen_b),
        .ram_bwen_a(ram_bwen_a), .ram_bwen_b(ram_bwen_b),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_din_a(ram_din_a), .ram_din_b(ram_din_b),
        .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [BW-1:0] m);
        logic [DW-1:0] r;
        for (int b = 0; b < BW; b++) r[8*b +: 8] = m[b] ? nw[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    // Dual-port RAM with registered read data and async-cleared contents.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            ram_dout_a <= '0;
            ram_dout_b <= '0;
        end else if (ram_cen) begin
            if (!ram_wen_a) ram_dout_a <= mem[ram_addr_a];
            if (!ram_wen_b) ram_dout_b <= mem[ram_addr_b];
            if (ram_wen_a) mem[ram_addr_a] <= merge(mem[ram_addr_a], ram_din_a, ram_bwen_a);
            if (ram_wen_b) mem[ram_addr_b] <= merge(mem[ram_addr_b], ram_din_b, ram_bwen_b);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mptr = 0;
        exp_rv = '0;
        exp_rd = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    endtask

    task automatic put(input int i, input logic w, input logic [AW-1:0] ad, input logic [BW-1:0] m, input logic [DW-1:0] dd);
        req_valid[i] = 1'b1;
        req_wen[i] = w;
        a[i] = ad;
        be[i] = m;
        d[i] = dd;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Settle inputs, predict this cycle's grants and RAM drive, compare, then advance the model.
    task automatic eval();
        int g0, g1, j;
        int gs[2];
        logic [N-1:0] nrv;
        logic [N*DW-1:0] nrd;
        logic ewa, ewb;
        logic [BW-1:0] eba, ebb;
        logic [AW-1:0] eaa, eab;
        logic [DW-1:0] eda, edb;
        #1;
        g0 = -1;
        g1 = -1;
        if (reset_n)
            for (int k = 0; k < N; k++) begin
                j = (mptr + k) % N;
                if (req_valid[j]) begin
                    if (g0 < 0) g0 = j;
                    else if (g1 < 0) g1 = j;
                end
            end
        if (g1 >= 0 && a[g0] == a[g1] && (req_wen[g0] || req_wen[g1])) g1 = -1;
        exp_ready = '0;
        {ewa, ewb, eba, ebb, eaa, eab, eda, edb} = '0;
        if (g0 >= 0) begin
            exp_ready[g0] = 1'b1;
            ewa = req_wen[g0]; eba = be[g0]; eaa = a[g0]; eda = d[g0];
        end
        if (g1 >= 0) begin
            exp_ready[g1] = 1'b1;
            ewb = req_wen[g1]; ebb = be[g1]; eab = a[g1]; edb = d[g1];
        end
        chk("req_ready", req_ready, exp_ready);
        chk("ram_cen", ram_cen, g0 >= 0);
        chk("ram_wen_a", ram_wen_a, ewa);
        chk("ram_bwen_a", ram_bwen_a, eba);
        chk("ram_addr_a", ram_addr_a, eaa);
        chk("ram_din_a", ram_din_a, eda);
        chk("ram_wen_b", ram_wen_b, ewb);
        chk("ram_bwen_b", ram_bwen_b, ebb);
        chk("ram_addr_b", ram_addr_b, eab);
        chk("ram_din_b", ram_din_b, edb);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("rsp_data", rsp_data, exp_rd);
        nrv = '0;
        nrd = '0;
        gs = '{g0, g1};
        foreach (gs[x])
            if (gs[x] >= 0 && !req_wen[gs[x]]) begin
                nrv[gs[x]] = 1'b1;
                nrd[gs[x]*DW +: DW] = ref_mem[a[gs[x]]];
            end
        foreach (gs[x])
            if (gs[x] >= 0 && req_wen[gs[x]])
                ref_mem[a[gs[x]]] = merge(ref_mem[a[gs[x]]], d[gs[x]], be[gs[x]]);
`ifndef RAM_DP_ARBITER_FIXED_PRIO_EN
        if (g1 >= 0) mptr = (g1 + 1) % N;
        else if (g0 >= 0) mptr = (g0 + 1) % N;
`endif
        exp_rv = nrv;
        exp_rd = nrd;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            a[i] = '0; be[i] = '0; d[i] = '0;
        end
        model_reset();
        for (int i = 0; i < N; i++) put(i, 1'b0, AW'(i), 4'hF, 32'h0);
        eval();
        req_valid = '0;
        reset_n = 1'b1;
        tick();

        // single read after write
        put(0, 1'b1, 4'd3, 4'hF, 32'hA5A5A5A5); eval(); tick(); req_valid = '0;
        put(0, 1'b0, 4'd3, 4'hF, 32'h0); eval();
        chk("single_ready0", req_ready[0], 1'b1);
        chk("single_addr_a", ram_addr_a, 4'd3);
        tick(); req_valid = '0; eval();
        chk("single_rsp_valid0", rsp_valid[0], 1'b1);
        chk("single_rsp_data0", rsp_data[31:0], 32'hA5A5A5A5);
        tick();

        // dual grant
        put(1, 1'b1, 4'd2, 4'hF, 32'h11223344); put(3, 1'b0, 4'd5, 4'hF, 32'h0); eval();
        chk("dual_ready", req_ready, 4'b1010);
        chk("dual_wen_a", ram_wen_a, 1'b1);
        chk("dual_addr_b", ram_addr_b, 4'd5);
        tick(); req_valid = '0; eval();
        chk("dual_rsp_valid", rsp_valid, 4'b1000);
        tick();

        // same-address conflict
        put(0, 1'b1, 4'd7, 4'hF, 32'hCAFEF00D); put(1, 1'b0, 4'd7, 4'hF, 32'h0); eval();
        chk("conflict_ready", req_ready, 4'b0001);
        chk("conflict_wen_b", ram_wen_b, 1'b0);
        tick(); req_valid[0] = 1'b0; eval();
        chk("conflict_retry_ready", req_ready, 4'b0010);
        tick(); req_valid = '0; eval();
        chk("conflict_new_data", rsp_data[63:32], 32'hCAFEF00D);
        tick();

        // byte mask
        put(2, 1'b1, 4'd1, 4'hF, 32'hFFFFFFFF); eval(); tick();
        put(2, 1'b1, 4'd1, 4'h5, 32'h00000000); eval(); tick();
        put(2, 1'b0, 4'd1, 4'hF, 32'h0); eval(); tick();
        req_valid = '0; eval();
        chk("bytemask_data", rsp_data[95:64], 32'hFF00FF00);
        tick();

        // reset while a read is in flight
        put(2, 1'b0, 4'd1, 4'hF, 32'h0); eval();
        chk("rst_read_granted", req_ready[2], 1'b1);
        reset_n = 1'b0;
        model_reset();
        eval();
        chk("rst_ram_addr_a", ram_addr_a, 4'd0);
        tick(); eval();
        chk("rst_rsp_valid", rsp_valid, 4'b0);
        reset_n = 1'b1; req_valid = '0;
        tick(); eval();
        chk("rst_after_release_rsp", rsp_valid, 4'b0);
        tick();

        // fairness with all requesters busy
        for (int i = 0; i < N; i++) begin
            put(i, 1'b0, AW'(8 + i), 4'hF, 32'h0);
            cnt[i] = 0;
        end
        for (int c = 0; c < 8; c++) begin
            eval();
            for (int i = 0; i < N; i++) cnt[i] += int'(req_ready[i]);
`ifdef RAM_DP_ARBITER_FIXED_PRIO_EN
            chk("fair_pair", req_ready, 4'b0011);
`else
            chk("fair_pair", req_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
`endif
            tick();
        end
        for (int i = 0; i < N; i++) begin
`ifdef RAM_DP_ARBITER_FIXED_PRIO_EN
            chk($sformatf("fair_cnt%0d", i), 128'(cnt[i]), (i < 2) ? 128'd8 : 128'd0);
`else
            chk($sformatf("fair_cnt%0d", i), 128'(cnt[i]), 128'd4);
`endif
        end
        req_valid = '0; eval(); tick();

        // random traffic; a requester keeps its payload until accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!(req_valid[i] && !exp_ready[i])) begin
                    req_valid[i] = ($urandom_range(0, 9) < 7);
                    req_wen[i] = 1'($urandom_range(0, 1));
                    a[i] = AW'($urandom_range(0, 3));
                    be[i] = BW'($urandom);
                    d[i] = $urandom;
                end
            eval();
            tick();
        end
        req_valid = '0; eval(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
